lsu_multi_outstanding: RTL

//  Load/store unit between ex1 and the MMU/D-cache port, allowing up to MAX_OUTSTANDING
//  in-flight mem requests. Checks alignment, issues addr phase, tracks requests in order,

---
 rtl/lsu_multi_outstanding.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_multi_outstanding.sv
// rtl/lsu_multi_outstanding.sv - in-order load/store unit with multiple outstanding MMU requests
package lsu_pkg;
    typedef enum logic [2:0] {
        EXCP_ALE  = 3'd0,
        EXCP_TLBR = 3'd1,
        EXCP_PIL  = 3'd2,
        EXCP_PIS  = 3'd3,
        EXCP_PPI  = 3'd4,
        EXCP_PME  = 3'd5
    } excp_t;
endpackage

module lsu_multi_outstanding
    import lsu_pkg::*;
#(
    parameter int  MAX_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        have_excp,
    output excp_t       excp_type,
    output logic        mmu_req,
    output logic [31:0] mmu_addr,
    output logic        mmu_we,
    output logic [1:0]  mmu_size,
    output logic [3:0]  mmu_wstrb,
    output logic [31:0] mmu_wdata,
    input  logic        mmu_addr_ok,
    input  logic        mmu_data_ok,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_tlbr,
    input  logic        mmu_pil,
    input  logic        mmu_pis,
    input  logic        mmu_ppi,
    input  logic        mmu_pme,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_store
);
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W:0]   MAX_OCC  = (CNT_W + 1)'(MAX_OUTSTANDING);

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    logic [1:0]  r_trk_off   [MAX_OUTSTANDING];
    logic [1:0]  r_trk_size  [MAX_OUTSTANDING];
    logic        r_trk_sign  [MAX_OUTSTANDING];
    logic        r_trk_store [MAX_OUTSTANDING];
    logic        r_trk_kill  [MAX_OUTSTANDING];
    logic [31:0] r_res_data  [MAX_OUTSTANDING];
    logic        r_res_store [MAX_OUTSTANDING];

    logic [IDX_W-1:0] r_trk_wr, r_trk_rd, r_res_wr, r_res_rd;
    logic [CNT_W-1:0] r_trk_cnt, r_res_cnt;

    logic        w_ale, w_full, w_trk_empty, w_res_empty, w_pop, w_live;
    logic        w_bypass, w_res_push, w_res_pop;
    logic [CNT_W:0] w_occ;
    logic [1:0]  w_head_off, w_head_size;
    logic        w_head_sign, w_head_store, w_head_kill;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_ale = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);

    always_comb begin
        excp_type = EXCP_ALE;
        if (w_ale)         excp_type = EXCP_ALE;
        else if (mmu_tlbr) excp_type = EXCP_TLBR;
        else if (mmu_pil)  excp_type = EXCP_PIL;
        else if (mmu_pis)  excp_type = EXCP_PIS;
        else if (mmu_ppi)  excp_type = EXCP_PPI;
        else if (mmu_pme)  excp_type = EXCP_PME;
    end
    assign have_excp = req_valid && (w_ale || mmu_tlbr || mmu_pil || mmu_pis || mmu_ppi || mmu_pme);

    // Occupancy counts buffered results too, so wb back-pressure throttles issue.
    assign w_occ     = {1'b0, r_trk_cnt} + {1'b0, r_res_cnt};
    assign w_full    = (w_occ == MAX_OCC);
    assign mmu_req   = req_valid && !w_ale && !w_full && !cancel;
    assign req_ready = mmu_req && mmu_addr_ok;
    assign mmu_addr  = req_addr;
    assign mmu_we    = req_store;
    assign mmu_size  = req_size;

    always_comb begin
        mmu_wstrb = 4'b1111;
        mmu_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                mmu_wstrb = 4'b0001 << req_addr[1:0];
                mmu_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                mmu_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                mmu_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_trk_empty  = (r_trk_cnt == '0);
    assign w_res_empty  = (r_res_cnt == '0);
    assign w_head_off   = r_trk_off[r_trk_rd];
    assign w_head_size  = r_trk_size[r_trk_rd];
    assign w_head_sign  = r_trk_sign[r_trk_rd];
    assign w_head_store = r_trk_store[r_trk_rd];
    assign w_head_kill  = r_trk_kill[r_trk_rd];

    assign w_byte = mmu_rdata[{w_head_off, 3'b000} +: 8];
    assign w_half = w_head_off[1] ? mmu_rdata[31:16] : mmu_rdata[15:0];

    always_comb begin
        w_ext = mmu_rdata;
        case (w_head_size)
            2'd0:    w_ext = {{24{w_head_sign & w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{w_head_sign & w_half[15]}}, w_half};
            default: ;
        endcase
        if (w_head_store) w_ext = '0;
    end

    // A data_ok with nothing tracked is stray (e.g. from before a reset) and is ignored.
    assign w_pop      = mmu_data_ok && !w_trk_empty;
    assign w_live     = w_pop && !w_head_kill && !cancel;
    assign w_bypass   = w_live && w_res_empty && resp_ready;
    assign w_res_push = w_live && !w_bypass;
    assign w_res_pop  = !cancel && !w_res_empty && resp_ready;

    assign resp_valid = !cancel && (!w_res_empty || w_bypass);
    assign resp_data  = w_res_empty ? w_ext : r_res_data[r_res_rd];
    assign resp_store = w_res_empty ? w_head_store : r_res_store[r_res_rd];

    always_ff @(posedge clk) begin
        if (req_ready) begin
            r_trk_off[r_trk_wr]   <= req_addr[1:0];
            r_trk_size[r_trk_wr]  <= req_size;
            r_trk_sign[r_trk_wr]  <= req_sign;
            r_trk_store[r_trk_wr] <= req_store;
        end
        if (w_res_push) begin
            r_res_data[r_res_wr]  <= w_ext;
            r_res_store[r_res_wr] <= w_head_store;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_trk_wr  <= '0;
            r_trk_rd  <= '0;
            r_trk_cnt <= '0;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_trk_kill[i] <= 1'b0;
        end else begin
            if (req_ready) begin
                r_trk_kill[r_trk_wr] <= 1'b0;
                r_trk_wr <= ptr_inc(r_trk_wr);
            end
            if (w_pop) r_trk_rd <= ptr_inc(r_trk_rd);
            r_trk_cnt <= r_trk_cnt + CNT_W'(req_ready) - CNT_W'(w_pop);
            // Killed entries keep their slot until the MMU returns their data.
            if (cancel) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) r_trk_kill[i] <= 1'b1;
                r_res_wr  <= '0;
                r_res_rd  <= '0;
                r_res_cnt <= '0;
            end else begin
                if (w_res_push) r_res_wr <= ptr_inc(r_res_wr);
                if (w_res_pop)  r_res_rd <= ptr_inc(r_res_rd);
                r_res_cnt <= r_res_cnt + CNT_W'(w_res_push) - CNT_W'(w_res_pop);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) !(mmu_data_ok && w_trk_empty));

endmodule
